// File: rtl/mm_pkg.sv
// Shared widths, grant encodings and FSM state type for the memory-port arbiter.
package mm_pkg;
  localparam int MM_ADDR_W = 11;
  localparam int MM_DATA_W = 32;

  // Grant code doubles as the requester index used by the round-robin pointer.
  typedef enum logic [1:0] {
    GNT_IF   = 2'b00,
    GNT_LD   = 2'b01,
    GNT_ST   = 2'b10,
    GNT_NONE = 2'b11
  } grant_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESPOND
  } state_e;

  function automatic grant_e oh2grant(input logic [2:0] oh);
    grant_e g;
    case (oh)
      3'b001:  g = GNT_IF;
      3'b010:  g = GNT_LD;
      3'b100:  g = GNT_ST;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin picker: search starts just after the last granted requester.
module rr_arbiter3
  import mm_pkg::*;
(
  input  logic   [2:0] req,
  input  grant_e       last,
  output logic   [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (last)
      GNT_IF: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      GNT_LD: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mm_port_arbiter.sv
// Shares one fixed-latency memory port among fetch, load and store requesters.
module mm_port_arbiter
  import mm_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 resetIn,
  input  logic                 ifReq,
  input  logic [31:0]          ifAddr,
  output logic                 ifAck,
  output logic [MM_DATA_W-1:0] ifData,
  input  logic                 ldReq,
  input  logic [31:0]          ldAddr,
  output logic                 ldAck,
  output logic [MM_DATA_W-1:0] ldData,
  input  logic                 stReq,
  input  logic [31:0]          stAddr,
  input  logic [MM_DATA_W-1:0] stData,
  output logic                 stAck,
  output logic [MM_ADDR_W-1:0] address,
  output logic [MM_DATA_W-1:0] dataWrite,
  output logic                 writeEnable,
  input  logic [MM_DATA_W-1:0] dataRead,
  output logic [1:0]           grant,
  output logic                 busy
);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY);

  state_e                 state_q, state_d;
  grant_e                 grant_q, grant_d, last_q, last_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [2:0]             ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   we_q, we_d;
  logic [MM_ADDR_W-1:0]   addr_q, addr_d;
  logic [MM_DATA_W-1:0]   wdata_q, wdata_d;
  logic [MM_DATA_W-1:0]   ifdata_q, ifdata_d;
  logic [MM_DATA_W-1:0]   lddata_q, lddata_d;

  logic [2:0] req_vec, gnt_oh;
  grant_e     win;

  // Only the low word-address bits reach the memory; the rest are don't-care.
  logic unused_hi;
  assign unused_hi = ^{ifAddr[31:MM_ADDR_W], ldAddr[31:MM_ADDR_W], stAddr[31:MM_ADDR_W]};

  assign req_vec = {stReq, ldReq, ifReq};

  rr_arbiter3 u_rr (
    .req  (req_vec),
    .last (last_q),
    .gnt  (gnt_oh)
  );

  assign win = oh2grant(gnt_oh);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ifdata_d = ifdata_q;
    lddata_d = lddata_q;
    ack_d    = 3'b000;
    we_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_vec) begin
          state_d = S_ACCESS;
          grant_d = win;
          last_d  = win;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          case (win)
            GNT_LD: addr_d = ldAddr[MM_ADDR_W-1:0];
            GNT_ST: begin
              addr_d  = stAddr[MM_ADDR_W-1:0];
              wdata_d = stData;
              we_d    = 1'b1;
            end
            default: addr_d = ifAddr[MM_ADDR_W-1:0];
          endcase
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        // Last access cycle: read data is valid now; register it alongside the ack.
        if (cnt_q == 3'd1) begin
          state_d = S_RESPOND;
          case (grant_q)
            GNT_IF: begin
              ack_d[0] = 1'b1;
              ifdata_d = dataRead;
            end
            GNT_LD: begin
              ack_d[1] = 1'b1;
              lddata_d = dataRead;
            end
            default: ack_d[2] = 1'b1;
          endcase
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetIn) begin
    if (!resetIn) begin
      state_q  <= S_IDLE;
      grant_q  <= GNT_NONE;
      last_q   <= GNT_ST;
      cnt_q    <= 3'd0;
      ack_q    <= 3'b000;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ifdata_q <= '0;
      lddata_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ifdata_q <= ifdata_d;
      lddata_q <= lddata_d;
    end
  end

  assign ifAck       = ack_q[0];
  assign ldAck       = ack_q[1];
  assign stAck       = ack_q[2];
  assign ifData      = ifdata_q;
  assign ldData      = lddata_q;
  assign address     = addr_q;
  assign dataWrite   = wdata_q;
  assign writeEnable = we_q;
  assign grant       = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Directed bench: single load/store, round-robin contention, dropped req, mid-access reset, latency 4.
module tb_mm_port_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        resetIn  = 1'b1;
  logic        ifReq = 1'b0, ldReq = 1'b0, stReq = 1'b0;
  logic [31:0] ifAddr = '0, ldAddr = '0, stAddr = '0, stData = '0, dataRead = '0;
  logic        ifAck, ldAck, stAck, writeEnable, busy;
  logic [31:0] ifData, ldData, dataWrite;
  logic [10:0] address;
  logic [1:0]  grant;

  logic        ifReq4 = 1'b0, ldReq4 = 1'b0, stReq4 = 1'b0;
  logic        ifAck4, ldAck4, stAck4, writeEnable4, busy4;
  logic [31:0] ifData4, ldData4, dataWrite4;
  logic [10:0] address4;
  logic [1:0]  grant4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  mm_port_arbiter #(.MEM_LATENCY(2)) dut (
    .CLOCK_50(CLOCK_50), .resetIn(resetIn),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifAck(ifAck), .ifData(ifData),
    .ldReq(ldReq), .ldAddr(ldAddr), .ldAck(ldAck), .ldData(ldData),
    .stReq(stReq), .stAddr(stAddr), .stData(stData), .stAck(stAck),
    .address(address), .dataWrite(dataWrite), .writeEnable(writeEnable),
    .dataRead(dataRead), .grant(grant), .busy(busy)
  );

  mm_port_arbiter #(.MEM_LATENCY(4)) dut4 (
    .CLOCK_50(CLOCK_50), .resetIn(resetIn),
    .ifReq(ifReq4), .ifAddr(ifAddr), .ifAck(ifAck4), .ifData(ifData4),
    .ldReq(ldReq4), .ldAddr(ldAddr), .ldAck(ldAck4), .ldData(ldData4),
    .stReq(stReq4), .stAddr(stAddr), .stData(stData), .stAck(stAck4),
    .address(address4), .dataWrite(dataWrite4), .writeEnable(writeEnable4),
    .dataRead(dataRead), .grant(grant4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; "cycle t+k" is the window after k edges.
  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [31:0] acks();
    return 32'({stAck, ldAck, ifAck});
  endfunction

  int order[4] = '{0, 1, 2, 0};

  initial begin
    #2 resetIn = 1'b0;
    cyc(); cyc();
    chk("rst_acks",  acks(), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_addr",  32'(address), 32'd0);
    chk("rst_we",    32'(writeEnable), 32'd0);
    chk("rst_dw",    dataWrite, 32'd0);
    chk("rst_ifd",   ifData, 32'd0);
    chk("rst_ldd",   ldData, 32'd0);
    resetIn = 1'b1;
    cyc();

    // single load
    ldReq = 1'b1; ldAddr = 32'h0000_0404; dataRead = 32'hDEAD_BEEF;
    cyc(); ldReq = 1'b0;
    chk("ld_addr_t1",  32'(address), 32'h404);
    chk("ld_busy_t1",  32'(busy), 32'd1);
    chk("ld_grant_t1", 32'(grant), 32'd1);
    chk("ld_acks_t1",  acks(), 32'd0);
    chk("ld_we_t1",    32'(writeEnable), 32'd0);
    cyc();
    chk("ld_addr_t2",  32'(address), 32'h404);
    chk("ld_acks_t2",  acks(), 32'd0);
    cyc();
    chk("ld_addr_t3",  32'(address), 32'h404);
    chk("ld_acks_t3",  acks(), 32'b010);
    chk("ld_data_t3",  ldData, 32'hDEAD_BEEF);
    cyc();
    chk("ld_acks_t4",  acks(), 32'd0);
    chk("ld_busy_t4",  32'(busy), 32'd0);
    chk("ld_grant_t4", 32'(grant), 32'd3);

    // single store; ldData must hold while the bus shows other data
    stReq = 1'b1; stAddr = 32'hFFFF_F805; stData = 32'h1234_5678; dataRead = 32'h1111_1111;
    cyc(); stReq = 1'b0;
    chk("st_addr_t1",  32'(address), 32'h005);
    chk("st_we_t1",    32'(writeEnable), 32'd1);
    chk("st_dw_t1",    dataWrite, 32'h1234_5678);
    chk("st_grant_t1", 32'(grant), 32'd2);
    cyc();
    chk("st_we_t2",    32'(writeEnable), 32'd0);
    chk("st_acks_t2",  acks(), 32'd0);
    cyc();
    chk("st_acks_t3",  acks(), 32'b100);
    chk("st_we_t3",    32'(writeEnable), 32'd0);
    chk("st_addr_t3",  32'(address), 32'h005);
    cyc();
    chk("st_acks_t4",  acks(), 32'd0);
    chk("st_ldhold",   ldData, 32'hDEAD_BEEF);

    // load whose req drops in t+2
    ldReq = 1'b1; ldAddr = 32'h0000_0010; dataRead = 32'hA5A5_A5A5;
    cyc();
    cyc(); ldReq = 1'b0;
    cyc();
    chk("drop_acks_t3", acks(), 32'b010);
    chk("drop_data_t3", ldData, 32'hA5A5_A5A5);
    cyc();
    chk("drop_busy_t4", 32'(busy), 32'd0);
    cyc();
    chk("drop_busy_t5", 32'(busy), 32'd0);
    chk("drop_grant_t5", 32'(grant), 32'd3);

    // all three held from reset: fetch, load, store, fetch
    resetIn = 1'b0;
    cyc();
    resetIn = 1'b1;
    ifReq = 1'b1; ldReq = 1'b1; stReq = 1'b1;
    ifAddr = 32'h0000_0100; ldAddr = 32'h0000_0200; stAddr = 32'h0000_0300;
    dataRead = 32'h0F0F_0F0F;
    for (int c = 1; c <= 16; c++) begin
      int ph, tx, eg, ea;
      cyc();
      ph = (c - 1) % 4;
      tx = (c - 1) / 4;
      eg = (ph == 3) ? 3 : order[tx];
      ea = (ph == 2) ? (1 << order[tx]) : 0;
      chk($sformatf("rr_grant_t%0d", c), 32'(grant), 32'(eg));
      chk($sformatf("rr_acks_t%0d", c), acks(), 32'(ea));
    end
    chk("rr_ifdata", ifData, 32'h0F0F_0F0F);
    ifReq = 1'b0; ldReq = 1'b0; stReq = 1'b0;
    cyc();

    // reset in the middle of a store access
    stReq = 1'b1; stAddr = 32'h0000_0077; stData = 32'hCAFE_0001;
    cyc();
    chk("mid_we_t1",   32'(writeEnable), 32'd1);
    chk("mid_busy_t1", 32'(busy), 32'd1);
    #2 resetIn = 1'b0;
    #1;
    chk("mid_we_rst",    32'(writeEnable), 32'd0);
    chk("mid_busy_rst",  32'(busy), 32'd0);
    chk("mid_grant_rst", 32'(grant), 32'd3);
    chk("mid_acks_rst",  acks(), 32'd0);
    chk("mid_addr_rst",  32'(address), 32'd0);
    cyc();
    chk("mid_acks_rst2", acks(), 32'd0);
    ifReq = 1'b1; ifAddr = 32'h0000_0123;
    resetIn = 1'b1;
    cyc();
    ifReq = 1'b0; stReq = 1'b0;
    chk("mid_grant_after", 32'(grant), 32'd0);
    chk("mid_addr_after",  32'(address), 32'h123);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      chk($sformatf("mid_acks_t%0d", c), acks(), (c == 3) ? 32'b001 : 32'd0);
    end

    // MEM_LATENCY = 4 fetch on the second instance
    ifReq4 = 1'b1; ifAddr = 32'h0000_0ABC; dataRead = 32'hCAFE_F00D;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) ifReq4 = 1'b0;
      if (c <= 5) chk($sformatf("l4_addr_t%0d", c), 32'(address4), 32'h2BC);
      chk($sformatf("l4_ack_t%0d", c), 32'(ifAck4), (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("l4_busy_t%0d", c), 32'(busy4), (c <= 5) ? 32'd1 : 32'd0);
    end
    chk("l4_ifdata", ifData4, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_port_arbiter.md
MM_PORT_ARBITER -- requirements
Module: mm_port_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 2, SHALL be the number of cycles from address issue to valid dataRead (legal range 1..7).
REQ-002 Port CLOCK_50, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port resetIn, input, 1: SHALL be an asynchronous, active-low reset.
REQ-004 Ports ifReq (input, 1), ifAddr (input, 32), ifAck (output, 1) and ifData (output, 32): the instruction-fetch read requester.
REQ-005 Ports ldReq (input, 1), ldAddr (input, 32), ldAck (output, 1) and ldData (output, 32): the load read requester.
REQ-006 Ports stReq (input, 1), stAddr (input, 32), stData (input, 32) and stAck (output, 1): the store write requester.
REQ-007 Ports address (output, 11), dataWrite (output, 32), writeEnable (output, 1) and dataRead (input, 32): the single main-memory port.
REQ-008 Ports grant (output, 2; 00 fetch, 01 load, 10 store, 11 none) and busy (output, 1): status outputs.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, ACCESS and RESPOND.
REQ-010 IDLE SHALL sample the requests; if any is high, it SHALL pick a winner, latch that winner's address (and stData for a store) and go to ACCESS.
REQ-011 Arbitration SHALL be round-robin: the search starts at the requester after the last granted one, in the cyclic order fetch -> load -> store -> fetch.
REQ-012 With t = the IDLE cycle in which the winner is sampled, address = latchedAddr[10:0] SHALL be driven from cycle t+1 through cycle t+MEM_LATENCY+1; bits [31:11] SHALL be ignored.
REQ-013 For a store, writeEnable SHALL be high only in cycle t+1, with dataWrite = latched stData; writeEnable SHALL be 0 in every other cycle and for all reads.
REQ-014 ACCESS SHALL last MEM_LATENCY cycles, timed by a 3-bit down-counter; for a read, dataRead SHALL be captured at the edge ending cycle t+MEM_LATENCY.
REQ-015 RESPOND SHALL occupy cycle t+MEM_LATENCY+1; the winner's ack SHALL be high for exactly that one cycle, and the FSM SHALL then return to IDLE.
REQ-016 ifData and ldData SHALL be registered, SHALL be valid in the ack cycle, and SHALL hold their value until the next completed read for that same requester.
REQ-017 An issued access SHALL never be aborted: if req drops during ACCESS, the transaction SHALL still complete and the ack SHALL still pulse.
REQ-018 Requests SHALL be sampled only in IDLE; a req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-019 At most one ack SHALL be high in any cycle.
REQ-020 busy SHALL be 1 in ACCESS and RESPOND; grant SHALL show the current winner in ACCESS and RESPOND, and 11 in IDLE.
REQ-021 Simultaneous requests SHALL each be served exactly once, in round-robin order; a requester held high SHALL wait at most two other transactions before it is granted.
REQ-022 Back-to-back throughput SHALL be one transaction per MEM_LATENCY+2 cycles.

Reset
REQ-023 While resetIn=0, the block SHALL immediately (asynchronously) go to IDLE, drive all acks 0, writeEnable 0, busy 0, grant 11, address 0, dataWrite 0, ifData 0 and ldData 0, and clear the counter.
REQ-024 Reset SHALL set the last-granted pointer to store, so fetch wins the first contention.
REQ-025 A reset during ACCESS SHALL abandon the transaction without any ack; the requester SHALL re-request after reset.

Structure
REQ-026 Package mm_pkg SHALL hold MM_ADDR_W=11, MM_DATA_W=32, the grant encodings, and the FSM state typedef.
REQ-027 Round-robin selection SHALL live in the sub-module rr_arbiter3, which takes the 3-bit request vector and last pointer and returns a one-hot winner; it SHALL be purely combinational.

Verification
REQ-028 The bench SHALL cover a single load: ldReq=1, ldAddr=0x0000_0404, memory returns 0xDEADBEEF -> address=0x404 from t+1, ldAck only at t+3, ldData=0xDEADBEEF.
REQ-029 The bench SHALL cover a store: stAddr=0xFFFF_F805, stData=0x12345678 -> address=0x005, writeEnable=1 only at t+1, dataWrite=0x12345678, stAck at t+3.
REQ-030 The bench SHALL cover all three reqs held high from reset -> grant order fetch, load, store, fetch, with acks at t+3, t+7, t+11, t+15.
REQ-031 The bench SHALL cover ldReq dropped in cycle t+2 -> ldAck still pulses at t+3, and no second load is issued.
REQ-032 The bench SHALL cover resetIn=0 asserted mid-ACCESS of a store -> writeEnable, busy and all acks go 0 immediately, no stAck; after release, fetch wins the first contention.
REQ-033 The bench SHALL cover MEM_LATENCY=4 with a fetch -> ifAck at t+5, address stable for t+1..t+5.
